// File: rtl/shift_rotate_seq_if.sv
// Control-unit handshake bundle for the iterative shift/rotate sequencer.
// Master drives the request, slave returns status and the Z result.
interface shift_rotate_seq_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [CNT_W-1:0] numRotates;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] z;

   modport master (
      output start, op, a, numRotates,
      input  busy, done, err, z
   );

   modport slave (
      input  start, op, a, numRotates,
      output busy, done, err, z
   );
endinterface

// File: rtl/shift_rotate_seq.sv
// Iterative shift/rotate sequencer replacing the barrel rotator for Z writeback.
// SHIFT_SEQ_FAST_STEP_EN: advance up to 4 bit positions per RUN cycle.
module shift_rotate_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic               clock,
   input logic               clear,
   shift_rotate_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [2:0] OpRol  = 3'b000;
   localparam logic [2:0] OpRor  = 3'b001;
   localparam logic [2:0] OpShl  = 3'b010;
   localparam logic [2:0] OpShr  = 3'b011;
   localparam logic [2:0] OpShra = 3'b100;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [CNT_W-1:0] rem;
   logic [2:0]       opReg;
   logic             busyReg;
   logic             doneReg;
   logic             errReg;
   logic [WIDTH-1:0] zReg;

   logic [CNT_W-1:0] amt;
   logic [WIDTH-1:0] stepped;

   function automatic logic [WIDTH-1:0] step1(
      input logic [WIDTH-1:0] w,
      input logic [2:0]       o
   );
      logic [WIDTH-1:0] r;
      r = w;
      unique case (1'b1)
         (o == OpRol):  r = {w[WIDTH-2:0], w[WIDTH-1]};
         (o == OpRor):  r = {w[0], w[WIDTH-1:1]};
         (o == OpShl):  r = {w[WIDTH-2:0], 1'b0};
         (o == OpShr):  r = {1'b0, w[WIDTH-1:1]};
         (o == OpShra): r = {w[WIDTH-1], w[WIDTH-1:1]};
         default:       r = w;
      endcase
      return r;
   endfunction

`ifdef SHIFT_SEQ_FAST_STEP_EN
   always_comb begin
      amt     = (rem > CNT_W'(4)) ? CNT_W'(4) : rem;
      stepped = work;
      for (int i = 0; i < 4; i++) begin
         if (CNT_W'(i) < amt) stepped = step1(stepped, opReg);
      end
   end
`else
   always_comb begin
      amt     = CNT_W'(1);
      stepped = step1(work, opReg);
   end
`endif

   // Done is raised on the edge leaving FIN; busy drops one edge later,
   // so a held start is only taken after that extra idle cycle.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state   <= IDLE;
         work    <= '0;
         rem     <= '0;
         opReg   <= '0;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         errReg  <= 1'b0;
         zReg    <= '0;
      end else begin
         doneReg <= 1'b0;
         unique case (state)
            IDLE: begin
               if (busyReg) begin
                  busyReg <= 1'b0;
               end else if (bus.start) begin
                  work    <= bus.a;
                  rem     <= bus.numRotates;
                  opReg   <= bus.op;
                  errReg  <= 1'b0;
                  busyReg <= 1'b1;
                  if (bus.op > OpShra || bus.numRotates == '0) begin
                     state <= FIN;
                     zReg  <= bus.a;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               work <= stepped;
               rem  <= rem - amt;
               if (rem == amt) begin
                  state <= FIN;
                  zReg  <= stepped;
               end
            end
            FIN: begin
               doneReg <= 1'b1;
               errReg  <= (opReg > OpShra);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busyReg;
   assign bus.done = doneReg;
   assign bus.err  = errReg;
   assign bus.z    = zReg;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed vector bench for shift_rotate_seq (both step-width builds).
// Checks latency, result, err, pulse width, and the handshake corner cases.
module tb_shift_rotate_seq;

   logic clock;
   logic clear;

   shift_rotate_seq_if #(.WIDTH(32), .CNT_W(5)) bus ();

   shift_rotate_seq #(.WIDTH(32), .CNT_W(5)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [4:0]  n;
      logic [31:0] expZ;
      logic        expErr;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int expLat(input logic [2:0] op, input logic [4:0] n);
      if (op > 3'b100 || n == 5'd0) return 1;
`ifdef SHIFT_SEQ_FAST_STEP_EN
      return (int'(n) + 3) / 4 + 1;
`else
      return int'(n) + 1;
`endif
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [4:0] n);
      @(negedge clock);
      bus.start      = 1'b1;
      bus.op         = op;
      bus.a          = a;
      bus.numRotates = n;
      @(posedge clock);
      #1;
      bus.start      = 1'b0;
      bus.op         = 3'($urandom);
      bus.a          = $urandom;
      bus.numRotates = 5'($urandom);
   endtask

   task automatic waitDone(output int lat);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clock);
         #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic runVec(input vec_t v);
      int lat;
      issue(v.op, v.a, v.n);
      check({v.name, " busy"}, 32'(bus.busy), 32'd1);
      waitDone(lat);
      check({v.name, " lat"}, 32'(lat), 32'(expLat(v.op, v.n)));
      check({v.name, " z"}, bus.z, v.expZ);
      check({v.name, " err"}, 32'(bus.err), 32'(v.expErr));
      @(posedge clock);
      #1;
      check({v.name, " pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
      check({v.name, " zhold"}, bus.z, v.expZ);
   endtask

   initial begin
      int lat;
      int pulses;
      vecs[0]  = '{"rolF4",   3'b000, 32'hF000_0000, 5'd4,  32'h0000_000F, 1'b0};
      vecs[1]  = '{"rol3",    3'b000, 32'h4000_0000, 5'd3,  32'h0000_0002, 1'b0};
      vecs[2]  = '{"ror1",    3'b001, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0};
      vecs[3]  = '{"shra31",  3'b100, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{"shr31",   3'b011, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
      vecs[5]  = '{"shl30",   3'b010, 32'h0000_0003, 5'd30, 32'hC000_0000, 1'b0};
      vecs[6]  = '{"zeroN",   3'b000, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
      vecs[7]  = '{"ill111",  3'b111, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b1};
      vecs[8]  = '{"rol9",    3'b000, 32'hF000_0000, 5'd9,  32'h0000_01E0, 1'b0};
      vecs[9]  = '{"ror8",    3'b001, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0};
      vecs[10] = '{"shl31",   3'b010, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0};
      vecs[11] = '{"shraPos", 3'b100, 32'h4000_0000, 5'd30, 32'h0000_0001, 1'b0};
      vecs[12] = '{"ill101",  3'b101, 32'hCAFE_0001, 5'd7,  32'hCAFE_0001, 1'b1};

      clear          = 1'b0;
      bus.start      = 1'b0;
      bus.op         = 3'b000;
      bus.a          = 32'h0;
      bus.numRotates = 5'd0;
      repeat (3) @(posedge clock);
      #1;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst err", 32'(bus.err), 32'd0);
      check("rst z", bus.z, 32'd0);
      @(negedge clock);
      clear = 1'b1;

      foreach (vecs[i]) runVec(vecs[i]);

      // start re-pulsed while RUN must be ignored
      issue(3'b000, 32'h0000_0001, 5'd12);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         bus.start      = 1'b1;
         bus.op         = 3'b011;
         bus.a          = 32'hFFFF_FFFF;
         bus.numRotates = 5'd1;
      end
      @(negedge clock);
      bus.start = 1'b0;
      lat = -1;
      for (int i = 3; i <= 200; i++) begin
         @(posedge clock);
         #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      check("ignore lat", 32'(lat), 32'(expLat(3'b000, 5'd12)));
      check("ignore z", bus.z, 32'h0000_1000);
      repeat (4) @(posedge clock);
      #1;
      check("ignore idle", 32'(bus.busy), 32'd0);

      // start held high: one idle cycle between operations
      @(negedge clock);
      bus.start      = 1'b1;
      bus.op         = 3'b000;
      bus.a          = 32'h0000_0001;
      bus.numRotates = 5'd1;
      waitDone(lat);
      check("b2b z1", bus.z, 32'h0000_0002);
      @(posedge clock);
      #1;
      check("b2b gap", {30'd0, bus.done, bus.busy}, 32'd0);
      @(posedge clock);
      #1;
      check("b2b reaccept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      waitDone(lat);
      check("b2b lat2", 32'(lat), 32'd2);
      @(posedge clock);
      @(posedge clock);

      // asynchronous clear in the middle of RUN
      issue(3'b000, 32'h0000_0003, 5'd20);
      @(posedge clock);
      #3;
      clear = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort z", bus.z, 32'd0);
      @(negedge clock);
      clear  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.done || bus.busy) pulses++;
      end
      check("abort nodone", 32'(pulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
